// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU adder types, word width and saturation constants.
package alu_pkg;
    localparam int WORD_W = 64;
    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, ADC = 2'd2} add_op_e;
    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic trunc;
    } add_flags_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} pkt_state_e;
    localparam logic [WORD_W-1:0] SAT_POS = {1'b0, {(WORD_W-1){1'b1}}};
    localparam logic [WORD_W-1:0] SAT_NEG = {1'b1, {(WORD_W-1){1'b0}}};
endpackage

// File: rtl/adder64_if.sv
// adder64_if: operand/result bundle between the sequencer and the 64-bit adder.
interface adder64_if;
    import alu_pkg::*;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] sum;
    logic              cin;
    logic              cout;
    logic              c63;
    modport inst (output a, b, cin, input sum, cout, c63);
    modport dut  (input a, b, cin, output sum, cout, c63);
endinterface

// File: rtl/adder64.sv
// adder64: combinational 64-bit adder exposing carry-out and the carry into the sign bit.
module adder64
    import alu_pkg::*;
(
    adder64_if.dut bus
);
    logic [WORD_W-1:0] lo;
    assign lo = {1'b0, bus.a[WORD_W-2:0]} + {1'b0, bus.b[WORD_W-2:0]} + WORD_W'(bus.cin);
    assign {bus.cout, bus.sum} = {1'b0, bus.a} + {1'b0, bus.b} + (WORD_W+1)'(bus.cin);
    assign bus.c63 = lo[WORD_W-1];
endmodule

// File: rtl/add64_seq.sv
// add64_seq: two-stage multi-beat ADD/SUB sequencer around adder64 (ADD64_SEQ_SAT_EN enables single-beat saturation).
module add64_seq
    import alu_pkg::*;
#(
    parameter int MAX_BEATS   = 4,
    parameter bit NEG_ON_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  add_op_e           in_op,
    input  logic              in_cin,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output add_flags_t        out_flags
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_END = CW'(MAX_BEATS - 1);

    logic              s1_valid_q, s1_cin_q, s1_last_q;
    logic [WORD_W-1:0] s1_a_q, s1_b_q;
    add_op_e           op_q;
    pkt_state_e        state_q, state_d;
    logic              chain_c_q, zero_acc_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              out_valid_q, out_last_q;
    logic [WORD_W-1:0] out_sum_q, sum_d;
    add_flags_t        out_flags_q, flags_d;
    logic              s2_adv, accept, first, term, entering_first, show, ovf_raw, sum_zero;

    adder64_if add_if ();
    adder64 u_adder (.bus(add_if.dut));

    assign add_if.a   = s1_a_q;
    assign add_if.b   = (op_q == SUB) ? ~s1_b_q : s1_b_q;
    assign add_if.cin = !first ? chain_c_q : (op_q == SUB) ? 1'b1 : (op_q == ADC) ? s1_cin_q : 1'b0;

    assign s2_adv    = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_flags = out_flags_q;

    // Packet bookkeeping, result flags and next packet state for the beat in S1
    always_comb begin
        first          = (state_q == IDLE);
        term           = s1_last_q || (beat_cnt_q == CNT_END);
        entering_first = s1_valid_q ? term : first;
        show           = !NEG_ON_LAST || term;
        ovf_raw        = add_if.c63 ^ add_if.cout;
        sum_zero       = (add_if.sum == '0);
        flags_d        = '{carry: add_if.cout, zero: zero_acc_q && sum_zero,
                           neg: show && add_if.sum[WORD_W-1], ovf: show && ovf_raw,
                           trunc: term && !s1_last_q};
`ifdef ADD64_SEQ_SAT_EN
        sum_d          = (first && s1_last_q && ovf_raw) ?
                         (add_if.sum[WORD_W-1] ? SAT_POS : SAT_NEG) : add_if.sum;
`else
        sum_d          = add_if.sum;
`endif
        state_d        = s2_adv ? (term ? IDLE : BUSY) : state_q;
    end

    // S1 operand register; the op is latched only when a packet's first beat enters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            op_q       <= ADD;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (accept) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_cin_q  <= in_cin;
                s1_last_q <= in_last;
            end
            if (accept && entering_first) op_q <= in_op;
        end
    end

    // Packet state, carry chain, beat count and running zero flag advance with S1 -> S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chain_c_q  <= 1'b0;
            beat_cnt_q <= '0;
            zero_acc_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (s2_adv) begin
                chain_c_q  <= add_if.cout;
                beat_cnt_q <= term ? '0 : beat_cnt_q + 1'b1;
                zero_acc_q <= term || (zero_acc_q && sum_zero);
            end
        end
    end

    // S2 result register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_flags_q <= '0;
        end else if (s2_adv) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_last_q  <= term;
            out_flags_q <= flags_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add64_seq.sv
// tb_add64_seq: directed scoreboard bench for add64_seq.
module tb_add64_seq;
    import alu_pkg::*;
    localparam int MAX_BEATS = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_cin, in_last, out_valid, out_ready, out_last;
    add_op_e     in_op;
    logic [63:0] in_a, in_b, out_sum;
    add_flags_t  out_flags;

    typedef struct packed {
        logic [63:0] sum;
        logic        last;
        add_flags_t  flags;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    bit      m_busy = 0;
    int      m_cnt  = 0;
    bit      m_chain = 0;
    bit      m_zacc = 1;
    add_op_e m_op = ADD;

    add64_seq #(.MAX_BEATS(MAX_BEATS), .NEG_ON_LAST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_cin(in_cin), .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_chain = 0; m_zacc = 1; m_op = ADD;
    endtask

    task automatic model_push(input add_op_e op, input logic cin, input logic [63:0] a,
                              input logic [63:0] b, input logic last);
        logic [63:0] bb;
        logic [64:0] r;
        logic        ci, term, ovf;
        bit          first;
        exp_t        e;
        first = !m_busy;
        if (first) m_op = op;
        bb   = (m_op == SUB) ? ~b : b;
        ci   = !first ? m_chain : (m_op == SUB) ? 1'b1 : (m_op == ADC) ? cin : 1'b0;
        r    = {1'b0, a} + {1'b0, bb} + 65'(ci);
        term = last || (m_cnt == MAX_BEATS - 1);
        ovf  = (a[63] == bb[63]) && (r[63] != a[63]);
        e.sum = r[63:0];
`ifdef ADD64_SEQ_SAT_EN
        if (first && last && ovf) e.sum = a[63] ? SAT_NEG : SAT_POS;
`endif
        e.last  = term;
        e.flags = '{carry: r[64], zero: m_zacc && (r[63:0] == 0), neg: term && r[63],
                    ovf: term && ovf, trunc: term && !last};
        sb.push_back(e);
        m_chain = r[64];
        m_zacc  = term || (m_zacc && (r[63:0] == 0));
        m_cnt   = term ? 0 : m_cnt + 1;
        m_busy  = !term;
    endtask

    task automatic send(input add_op_e op, input logic cin, input logic [63:0] a,
                        input logic [63:0] b, input logic last);
        bit acc = 0;
        int n = 0;
        in_valid = 1; in_op = op; in_cin = cin; in_a = a; in_b = b; in_last = last;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_accept observed=%0d expected=1", acc);
        end
        if (acc) model_push(op, cin, a, b, last);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        #1;
    endtask

    // Scoreboard: every result beat taken by the consumer is matched in order
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed=%h expected=none", out_sum);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sum", out_sum, e.sum);
                check("last", 64'(out_last), 64'(e.last));
                check("flags", 64'(out_flags), 64'(e.flags));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_op = ADD; in_cin = 0; in_a = 0; in_b = 0; in_last = 0;
        out_ready = 1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; rst = 0;

        send(ADD, 0, ONES, 64'd1, 1);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        drain();

        send(ADD, 0, ONES, 64'd1, 0);
        send(ADD, 0, 64'd0, 64'd0, 1);
        send(SUB, 0, 64'd0, 64'd1, 0);
        send(SUB, 0, 64'd1, 64'd0, 1);
        send(ADC, 1, 64'd1, 64'd2, 1);
        send(SUB, 0, 64'd5, 64'd7, 1);
        send(ADD, 0, ONES, 64'd1, 1);
        send(ADD, 0, 64'd0, 64'd0, 1);
        drain();

        out_ready = 0;
        send(ADD, 0, 64'd10, 64'd1, 1);
        send(ADD, 0, 64'd20, 64'd2, 1);
        in_valid = 1; in_op = ADD; in_a = 64'd30; in_b = 64'd3; in_last = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold_sum", out_sum, sb[0].sum);
        end
        @(posedge clk); #1;
        out_ready = 1;
        send(ADD, 0, 64'd30, 64'd3, 1);
        drain();

        for (int i = 0; i < 5; i++) send(ADD, 0, ONES, 64'd1, 0);
        send(ADD, 0, 64'd0, 64'd0, 1);
        drain();

        send(ADD, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
        send(SUB, 0, 64'h8000_0000_0000_0000, 64'd1, 1);
        drain();

        out_ready = 0;
        send(ADD, 0, ONES, 64'd1, 0);
        @(posedge clk); #2;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        send(ADD, 0, 64'd5, 64'd6, 1);
        drain();
        check("end_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add64_seq.md
Name: add64_seq

Overview:
- Sequencing stage directly upstream of adder64.
- Accepts operand beats over a valid/ready handshake and registers them (S1) in front of an adder64 instance.
- Chains carry across beats so 64·N-bit ADD/SUB runs as a multi-beat packet.
- Registers each result beat with status flags (S2) for the ALU writeback consumer.

Parameters:
- MAX_BEATS, 4, max beats per packet (≥1); longer packets are force-terminated.
- NEG_ON_LAST, 1, 1 = negative/overflow flags valid only on the last beat; 0 = on every beat.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  stage can accept a beat
- in_op  in  alu_pkg::add_op_e (2)  ADD=0, SUB=1, ADC=2 (ADD with in_cin); sampled on first beat only
- in_cin  in  1  external carry-in; used on first beat when op=ADC
- in_a  in  64  operand A word, least-significant beat first
- in_b  in  64  operand B word
- in_last  in  1  final beat of packet
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_sum  out  64  result word
- out_last  out  1  final beat (in_last, or forced at MAX_BEATS)
- out_flags  out  alu_pkg::add_flags_t (5)  {carry, zero, neg, ovf, trunc}

Behaviour:
- Reset (async, immediate): out_valid=0, out_sum=0, out_last=0, out_flags=0, s1_valid=0, in_packet=0, chain_c=0, beat_cnt=0, zero_acc=1, latched op=ADD.
- in_ready reflects state (s1_valid and S2 occupancy) only; it has no combinational path from in_valid.
- Handshake:
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_adv
  - Beat accepted when in_valid && in_ready.
  - Full throughput: 1 beat/cycle.
  - Latency: 2 cycles from acceptance to out_valid (S1 reg → adder64 comb → S2 reg).
- Outputs hold stable while out_valid && !out_ready.
- Adder drive (from S1 regs):
  - op1 = a.
  - op2 = b for ADD/ADC, ~b for SUB.
  - carry_in on first beat: ADD=0, SUB=1, ADC=s1_cin.
  - carry_in on later beats: chain_c.
- Packet FSM, states IDLE (in_packet=0) and BUSY (in_packet=1), transitions on s2_adv:
  - IDLE → BUSY when beat is not last.
  - BUSY → IDLE when beat is last or beat_cnt==MAX_BEATS-1.
  - A beat that is both first and last stays in IDLE.
  - chain_c ← adder carry_out on every s2_adv.
  - Op latched when a first beat enters S1; in_op of non-first beats is ignored.
- Flags, captured into S2:
  - carry = carry_out. For SUB, carry=1 means no borrow.
  - zero = zero_acc && (sum==0), where zero_acc ANDs across the packet and resets to 1 after the last beat. It reports zero for the whole packet on the last beat; earlier beats carry the partial value.
  - neg = sum[63].
  - ovf = signed overflow (carry into bit 63 XOR carry_out).
  - With NEG_ON_LAST=1, neg and ovf are forced to 0 on non-last beats.
  - trunc = 1 only on a beat force-terminated at MAX_BEATS without in_last. That beat is output with out_last=1.
- Back-to-back packets: a first beat entering S1 in the same cycle a last beat leaves S1 uses the first-beat carry rule, never chain_c.
- Reset mid-packet: in-flight beats are dropped, and the next accepted beat is a first beat.

Optional Feature:
- Macro: ADD64_SEQ_SAT_EN.
- Defined: single-beat packets (in_last on first beat) with ovf=1 saturate out_sum to 0x7FFF_FFFF_FFFF_FFFF (positive overflow) or 0x8000_0000_0000_0000 (negative overflow). ovf stays 1; carry is unchanged. Multi-beat packets never saturate.
- Undefined: out_sum is always the raw adder result, and no saturation logic is synthesized.

Decomposition:
- alu_pkg holds:
  - add_op_e enum
  - add_flags_t packed struct {carry, zero, neg, ovf, trunc}
  - localparam WORD_W=64
  - SAT_POS/SAT_NEG constants
- Sub-module: the existing adder64, driven through an adder64_if instance, modport inst.
- The packet FSM stays inline; no further sub-module.

Test Plan:
- ADD single beat, a=0xFFFF_FFFF_FFFF_FFFF, b=1 → 2 cycles later sum=0, flags carry=1, zero=1, ovf=0, out_last=1.
- 128-bit ADD, beats (a0=0xFFFF_FFFF_FFFF_FFFF, b0=1), (a1=0, b1=0, last) → sum0=0 (carry=1), sum1=1, carry=0, zero=0.
- 128-bit SUB, 0x1_0000000000000000 − 1: beats (a0=0, b0=1), (a1=1, b1=0, last) → sum0=0xFFFF_FFFF_FFFF_FFFF, sum1=0, carry=1.
- out_ready held low 5 cycles with 3 beats offered → in_ready drops after 2 beats are buffered, outputs hold stable, no beat lost or duplicated, order preserved.
- MAX_BEATS=4, 5-beat packet without in_last → beat 4 has out_last=1 and trunc=1; beat 5 is treated as a new packet first beat (carry_in=0 for ADD).
- Signed ADD, a=0x7FFF_FFFF_FFFF_FFFF, b=1, single beat → ovf=1, neg=1; with ADD64_SEQ_SAT_EN sum=0x7FFF_FFFF_FFFF_FFFF; rst asserted mid-packet → out_valid=0 immediately, next beat uses first-beat carry.
